// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache.
//   Sits between the fetch stage (AXI read slave side, s_*) and the memory
//   AXI4 read port (m_*). A hit is presented in the cycle after the address
//   handshake. A miss refills the whole line with one INCR burst of WORDS
//   beats. The pulse 'invalidate' (fence.i) clears every valid bit.
// Ports:
//   aclk, areset         clock, synchronous active-high reset
//   invalidate           pulse: clear all valid bits
//   s_ar* / s_r*         fetch address / instruction word channels
//   m_ar* / m_r*         refill burst request / refill beats
module icache #(
  parameter int          LINES = 64,
  parameter int          WORDS = 4,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        invalidate,
  input  logic        s_arvalid,
  output logic        s_arready,
  input  logic [31:0] s_araddr,
  input  logic [2:0]  s_arprot,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [1:0]  m_arburst,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast
);

  localparam int IW = $clog2(LINES);
  localparam int WW = $clog2(WORDS);
  localparam int TW = 30 - IW - WW;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_HIT, S_REFILL_AR, S_REFILL_R, S_RESPOND
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [31:2]     r_addr;
  logic [WW-1:0]   r_cnt;
  logic            r_err;
  logic            r_inv_seen;
  logic [31:0]     r_out;

  logic [31:0]     r_data [LINES*WORDS];
  logic [TW-1:0]   r_tag  [LINES];
  logic [LINES-1:0] r_valid;

  logic [WW-1:0]   w_word;
  logic [IW-1:0]   w_idx;
  logic [TW-1:0]   w_tag;
  logic            w_hit;
  logic            w_ar_hs;
  logic            w_beat;
  logic            w_last;
  logic            w_err_next;
  logic            w_unused;

  assign w_word = r_addr[2 +: WW];
  assign w_idx  = r_addr[2+WW +: IW];
  assign w_tag  = r_addr[31 -: TW];

  // invalidate in the lookup cycle wins over a matching tag
  assign w_hit   = r_valid[w_idx] & (r_tag[w_idx] == w_tag) & ~invalidate;
  assign w_ar_hs = s_arvalid & s_arready;
  assign w_beat  = (r_state == S_REFILL_R) & m_rvalid;
  assign w_last  = w_beat & m_rlast;

  // any non-OKAY beat, or rlast arriving on the wrong beat, poisons the refill
  assign w_err_next = r_err | (|m_rresp) | (m_rlast & (r_cnt != WW'(WORDS - 1)));

  assign m_araddr  = {r_addr[31:WW+2], {(WW+2){1'b0}}};
  assign m_arlen   = 8'(WORDS - 1);
  assign m_arburst = 2'b01;
  assign m_rready  = 1'b1;

  // the hit word goes straight out of the lookup cycle; later cycles replay r_out
  assign s_rdata = (r_state == S_LOOKUP) ? r_data[{w_idx, w_word}] : r_out;
  assign s_rresp = ((r_state == S_RESPOND) && r_err) ? 2'b10 : 2'b00;

  assign w_unused = ^{s_arprot, s_araddr[1:0], BASE};

  always_ff @(posedge aclk) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // A word is presented in LOOKUP (on a hit), HIT and RESPOND; all three share
  // the same exit rule so a back-to-back hit stream delivers one word per cycle.
  always_comb begin
    w_state_next = r_state;
    s_arready    = 1'b0;
    s_rvalid     = 1'b0;
    m_arvalid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        s_arready = 1'b1;
        if (s_arvalid) w_state_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (w_hit) begin
          s_rvalid = 1'b1;
          if (s_rready) begin
            s_arready    = 1'b1;
            w_state_next = s_arvalid ? S_LOOKUP : S_IDLE;
          end else begin
            w_state_next = S_HIT;
          end
        end else begin
          w_state_next = S_REFILL_AR;
        end
      end
      S_HIT, S_RESPOND: begin
        s_rvalid = 1'b1;
        if (s_rready) begin
          s_arready    = 1'b1;
          w_state_next = s_arvalid ? S_LOOKUP : S_IDLE;
        end
      end
      S_REFILL_AR: begin
        m_arvalid = 1'b1;
        if (m_arready) w_state_next = S_REFILL_R;
      end
      S_REFILL_R: begin
        if (w_last) w_state_next = S_RESPOND;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_addr     <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_inv_seen <= 1'b0;
      r_out      <= '0;
    end else begin
      if (w_ar_hs) r_addr <= s_araddr[31:2];
      if (r_state == S_LOOKUP) begin
        if (w_hit) begin
          r_out <= r_data[{w_idx, w_word}];
        end else begin
          r_cnt      <= '0;
          r_err      <= 1'b0;
          r_inv_seen <= 1'b0;
        end
      end
      if (((r_state == S_REFILL_AR) || (r_state == S_REFILL_R)) && invalidate)
        r_inv_seen <= 1'b1;
      if (w_beat) begin
        r_cnt <= r_cnt + WW'(1);
        r_err <= w_err_next;
        if (r_cnt == w_word) r_out <= m_rdata;
      end
    end
  end

  // data and tag storage need no reset: valid bits gate every use
  always_ff @(posedge aclk) begin
    if (w_beat) r_data[{w_idx, r_cnt}] <= m_rdata;
    if (w_last) r_tag[w_idx] <= w_tag;
  end

  // A miss drops the old line at once so a failed refill cannot leave a
  // half-overwritten line marked valid. invalidate beats any refill update.
  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
      always_ff @(posedge aclk) begin
        if (areset || invalidate) begin
          r_valid[gi] <= 1'b0;
        end else if (w_idx == IW'(gi)) begin
          if ((r_state == S_LOOKUP) && !w_hit) r_valid[gi] <= 1'b0;
          else if (w_last)                     r_valid[gi] <= ~w_err_next & ~r_inv_seen;
        end
      end
    end
  endgenerate

endmodule
